// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OPC_ADD = 3'b001;
    localparam logic [2:0] OPC_SUB = 3'b010;

    typedef logic req_id_t;

    // One-hot to requester id for the two-entry case.
    function automatic req_id_t onehot_to_id(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-input round-robin grant: combinational grant, registered last-served pointer.
module alu_rr_arbiter
    import alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  req_id_t    served_i,
    output logic [1:0] grant_o,
    output req_id_t    grant_id_o
);

    req_id_t last_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        grant_id_o = onehot_to_id(grant_o);
    end

    // Pointer moves only when a response completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update_i) begin
            last_q <= served_i;
        end else begin
            last_q <= last_q;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one external combinational ALU between two
// requesters: accept, drive registered operands for EXEC_CYCLES, capture, respond.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][WIDTH-1:0] req_inp1,
    input  logic [1:0][WIDTH-1:0] req_inp2,
    input  logic [1:0][2:0]       req_opc,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_overflow,
    output logic [WIDTH-1:0]      alu_inp1,
    output logic [WIDTH-1:0]      alu_inp2,
    output logic [2:0]            alu_opc,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_overflow,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_CYCLES - 1);

    state_t            state_q, state_d;
    req_id_t           id_q, id_d;
    logic [WIDTH-1:0]  inp1_q, inp1_d, inp2_q, inp2_d;
    logic [2:0]        opc_q, opc_d;
    logic [EW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic [1:0]        grant_s;
    req_id_t           grant_id_s;
    logic              accept_s;
    logic              resp_done_s;

    assign accept_s    = (state_q == IDLE) && (|(req_valid & grant_s));
    assign resp_done_s = (state_q == RESP) && resp_ready[id_q];

    alu_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_valid),
        .update_i   (resp_done_s),
        .served_i   (id_q),
        .grant_o    (grant_s),
        .grant_id_o (grant_id_s)
    );

    // Next-state and datapath register updates for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        inp1_d       = inp1_q;
        inp2_d       = inp2_q;
        opc_d        = opc_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        ovf_d        = ovf_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = EXEC;
                    id_d    = grant_id_s;
                    inp1_d  = req_inp1[grant_id_s];
                    inp2_d  = req_inp2[grant_id_s];
                    opc_d   = req_opc[grant_id_s];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    state_d      = RESP;
                    data_d       = alu_out;
                    ovf_d        = alu_overflow;
                    resp_valid_d = id_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q + EW'(1);
                end
            end
            RESP: begin
                if (resp_done_s) begin
                    state_d      = IDLE;
                    resp_valid_d = 2'b00;
                    busy_d       = 1'b0;
                    op_count_d   = op_count_q + CNT_W'(1);
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 2'b00;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= 1'b0;
            inp1_q       <= '0;
            inp2_q       <= '0;
            opc_q        <= 3'b000;
            cnt_q        <= '0;
            data_q       <= '0;
            ovf_q        <= 1'b0;
            resp_valid_q <= 2'b00;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            inp1_q       <= inp1_d;
            inp2_q       <= inp2_d;
            opc_q        <= opc_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            ovf_q        <= ovf_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready     = (state_q == IDLE) ? grant_s : 2'b00;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = data_q;
    assign resp_overflow = ovf_q;
    assign alu_inp1      = inp1_q;
    assign alu_inp2      = inp2_q;
    assign alu_opc       = opc_q;
    assign busy          = busy_q;
    assign op_count      = op_count_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin scheduler that shares the single combinational 16-bit ALU (operands, 3-bit opcode, result, overflow) between independent clients. It accepts a command over a valid/ready handshake and drives the ALU from registered operands for a fixed number of settle cycles. It then captures result and overflow and returns them to the issuing requester over a valid/ready response channel. It sits between the client logic and the ALU/seven-segment top; the ALU itself is external and unchanged.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- EXEC_CYCLES, 1, ALU settle cycles before capture (legal ≥1)
- CNT_W, 8, width of completed-operation counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester command valid
- req_ready  out  2  per-requester command accept
- req_inp1  in  2×WIDTH  operand A per requester
- req_inp2  in  2×WIDTH  operand B per requester
- req_opc  in  2×3  opcode per requester
- resp_valid  out  2  per-requester result valid
- resp_ready  in  2  per-requester result accept
- resp_data  out  WIDTH  captured ALU result (shared, qualified by resp_valid)
- resp_overflow  out  1  captured ALU overflow
- alu_inp1, alu_inp2  out  WIDTH  to ALU
- alu_opc  out  3  to ALU
- alu_out  in  WIDTH  from ALU
- alu_overflow  in  1  from ALU
- busy  out  1  high in any state except IDLE
- op_count  out  CNT_W  completed responses, wraps

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbiter picks the winner among asserted req_valid bits.
  - req_ready is combinationally high only for the winner; all other bits are 0.
  - Handshake (valid&ready) latches the winner's inp1/inp2/opc and its id, clears the exec counter, and moves to EXEC.
  - No valid: stay in IDLE.
- Arbitration:
  - If only one request is valid, it wins.
  - If both are valid, the requester not served last wins.
  - The last-served pointer updates on the response handshake only.
- EXEC:
  - alu_* driven from the latched registers (they are always driven from these registers, in every state).
  - Counter increments each cycle.
  - In the cycle where count == EXEC_CYCLES-1: capture alu_out/alu_overflow, then go to RESP.
- RESP:
  - resp_valid[id]=1; the other bit is 0.
  - resp_data/resp_overflow are held stable.
  - On resp_ready[id]: go to IDLE and increment op_count.
  - resp_ready on the non-issuing bit is ignored.
- Opcodes pass through unmodified. The block never interprets them; add and subtract results come entirely from the ALU.
- A requester may drop req_valid before handshake; nothing is latched in that case.
- op_count wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values:
  - state IDLE; req_ready 0 unless a request is present (combinational from IDLE).
  - resp_valid 0, resp_data 0, resp_overflow 0.
  - alu_inp1/alu_inp2/alu_opc 0, busy 0, op_count 0.
  - Last-served pointer = requester 1, so requester 0 wins the first tie.
- Latency:
  - Handshake at edge E0.
  - EXEC occupies EXEC_CYCLES cycles.
  - resp_valid is visible after edge E0+EXEC_CYCLES (EXEC_CYCLES=1: resp_valid in the second cycle after acceptance).
- Throughput: the next accept is the earliest cycle after the response handshake (IDLE). Minimum period is EXEC_CYCLES+2 cycles per operation.
- Back-to-back:
  - Response handshake at edge E moves to IDLE after E.
  - The new request can be accepted in that IDLE cycle.
  - There is no bypass from RESP to EXEC.
- Reset mid-operation (EXEC or RESP): aborts with no response, op_count not incremented, all outputs return to reset values on the next edge.
- resp_ready asserted early (before resp_valid) has no effect.

## Structure
- Package alu_arb_pkg:
  - State enum {IDLE, EXEC, RESP}.
  - Opcode constants OPC_ADD=3'b001, OPC_SUB=3'b010 (used by bench and clients).
  - Requester-id type (1 bit).
- Sub-module alu_rr_arbiter: 2-input round-robin grant with a last-served pointer and an update strobe; combinational grant, registered pointer.
- Top-level: FSM, operand/result registers, exec counter, op_count.

## Test plan
- Req0 1+2, OPC_ADD, EXEC_CYCLES=1 -> req_ready[0] in IDLE; resp_valid[0] two cycles later; resp_data=0x0003, overflow 0, op_count=1.
- Req1 1−2, OPC_SUB -> resp_valid[1] only; resp_data=0xFFFF, overflow 0.
- Req0 0x7FFF+0x0001 ADD -> resp_data=0x8000, resp_overflow=1.
- Both valid from reset -> req0 served first, then req1; with both held valid, grants alternate 0,1,0,1 for four operations.
- resp_ready held low 5 cycles -> resp_valid and resp_data stable and busy=1 throughout; no new req_ready.
- rst pulsed during EXEC -> no resp_valid; op_count unchanged; next request completes normally; 256 completions with CNT_W=8 wrap op_count to 0.
